uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
Far end of the 4-byte command / 2-byte response UART link.
- Collects 4 command bytes from a byte-level UART receiver and reassembles the 21-bit frame {mode, addr[11:0], data[7:0]}.
- Issues one local bus transaction, then returns a 2-byte response (data, flags) through a byte-level UART transmitter.
- Sits between the UART RX/TX cores and the slave-side bus port, on the peer system's side of the link.

Parameters:
BYTE_TIMEOUT, 50000, max clk cycles between consecutive command bytes before the partial frame is dropped
RESP_TIMEOUT, 1024, max clk cycles waiting for bus_ack before an error response is sent

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
uart_data_out  input  8  received byte from UART RX core
uart_ready  input  1  RX byte available; level, may stay high several cycles
uart_ready_clr  output  1  one-cycle pulse: byte consumed
uart_data_in  output  8  byte to UART TX core
uart_wr_en  output  1  one-cycle pulse: load uart_data_in into TX core
uart_tx_busy  input  1  TX core transmitting
bus_req  output  1  bus request, held until bus_ack
bus_mode  output  1  1 = write, 0 = read
bus_addr  output  12  bus address
bus_wdata  output  8  write data
bus_ack  input  1  one-cycle transaction complete
bus_rdata  input  8  read data, valid with bus_ack
busy  output  1  high in every state except IDLE
frame_err  output  1  one-cycle pulse on malformed frame, byte timeout or response timeout
cmd_count  output  16  completed responses, wraps 0xFFFF->0

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE; all outputs 0; internal registers and timers cleared. Reset mid-operation aborts everything, with no response and no err pulse.
- Byte format on the wire, in this order:
  - B0=data[7:0]
  - B1=addr[7:0]
  - B2={4'b0, addr[11:8]}
  - B3={7'b0, mode}
- Response format: R0=data; R1=flags {6'b0, err, is_write}.
- Byte acceptance is edge-qualified. A byte is taken when uart_ready=1 and the armed flag is set. Taking it pulses uart_ready_clr on the next cycle and clears armed. Armed re-sets once uart_ready is sampled 0. A 2-cycle ready hold therefore yields exactly one byte.
- States:
  - IDLE: accepting B0 -> RX1.
  - RX1, RX2, RX3: each accept stores the byte and advances.
  - RX3 on accept goes to CHECK.
  - CHECK (1 cycle):
    - If B2[7:4]!=0 or B3[7:1]!=0: frame_err pulse, -> IDLE.
    - Otherwise drive bus_* and set bus_req=1 -> WAIT_ACK.
  - WAIT_ACK:
    - On bus_ack: bus_req=0; resp_data = bus_rdata (read) or B0 echo (write); err=0 -> TX0.
    - On RESP_TIMEOUT expiry: bus_req=0; resp_data=0x00; err=1; frame_err pulse -> TX0.
  - TX0: when uart_tx_busy=0, present R0 on uart_data_in and pulse uart_wr_en for 1 cycle -> TXW0.
  - TXW0: ignore busy for 1 cycle (TX core latency), then wait for uart_tx_busy=0 -> TX1.
  - TX1: send R1 the same way -> TXW1.
  - TXW1: same wait; on exit cmd_count+1 -> IDLE.
- Byte timer:
  - Reset on every accepted byte; counts only in RX1..RX3.
  - Reaching BYTE_TIMEOUT: frame_err pulse, discard partial frame -> IDLE.
  - A byte arriving in the same cycle as expiry is accepted; the timeout loses.
- Bytes arriving during CHECK..TXW1 are not consumed. uart_ready_clr stays 0 and armed is held, so the byte is taken as B0 after return to IDLE.
- bus_addr, bus_mode and bus_wdata are stable from CHECK until bus_ack or timeout.
- bus_ack in the same cycle as RESP_TIMEOUT expiry counts as success.
- Latency from B3 accepted to R0 uart_wr_en (bus_ack in the first WAIT_ACK cycle, TX idle): 4 cycles.

Test Plan:
- Write: bytes AA,23,01,01, each with 2-cycle ready and 100-cycle gaps -> bus_req with mode=1, addr=0x123, wdata=0xAA; ack -> TX bytes CC-free echo AA then 01; cmd_count=1.
- Read: bytes 00,56,04,00; bus_ack with rdata=0xBB -> bus_addr=0x456, mode=0; TX bytes BB then 00. uart_wr_en waits each time for busy from a 100-cycle busy model.
- Malformed: B3=0x03 -> frame_err pulse, no bus_req, no TX bytes; next valid frame is processed normally.
- Byte timeout: send 2 bytes then silence for BYTE_TIMEOUT=200 -> frame_err at the gap, state IDLE. A following full frame decodes correctly.
- Response timeout: valid read, bus_ack never asserted, RESP_TIMEOUT=16 -> bus_req drops after 16 cycles; TX bytes 00 then 02.
- Reset mid-frame: assert rst during WAIT_ACK -> all outputs 0 next cycle, no TX, cmd_count=0.

Source files
------------

// File: rtl/uart_cmd_responder_if.sv
`timescale 1ns/1ps
// Local bus between the command responder (master) and the peer-side slave.
//   bus_req   : request, held until bus_ack
//   bus_mode  : 1 = write, 0 = read
//   bus_addr  : 12-bit address
//   bus_wdata : write data
//   bus_ack   : one-cycle completion from the slave
//   bus_rdata : read data, valid with bus_ack
interface uart_cmd_responder_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  logic              bus_req;
  logic              bus_mode;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_mode, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_mode, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/uart_cmd_responder.sv
`timescale 1ns/1ps
// Far end of the 4-byte command / 2-byte response UART link.
// Collects {data, addr_lo, addr_hi, mode} from the UART RX core, runs one
// local bus transaction and returns {data, flags} through the UART TX core.
//   clk, rst        : clock, synchronous active-high reset
//   uart_data_out   : RX byte          uart_ready     : RX byte available (level)
//   uart_ready_clr  : RX byte consumed (1-cycle pulse)
//   uart_data_in    : TX byte          uart_wr_en     : TX load (1-cycle pulse)
//   uart_tx_busy    : TX core transmitting
//   bus             : local bus, master side
//   busy            : not IDLE         frame_err      : malformed / timeout pulse
//   cmd_count       : completed responses (wraps)
module uart_cmd_responder #(
  parameter int unsigned BYTE_TIMEOUT = 50000,
  parameter int unsigned RESP_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  uart_data_out,
  input  logic                        uart_ready,
  output logic                        uart_ready_clr,
  output logic [7:0]                  uart_data_in,
  output logic                        uart_wr_en,
  input  logic                        uart_tx_busy,
  uart_cmd_responder_if.master        bus,
  output logic                        busy,
  output logic                        frame_err,
  output logic [15:0]                 cmd_count
);

  localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned RT_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, RX1, RX2, RX3, CHECK, WAIT_ACK, TX0, TXW0, TX1, TXW1
  } state_t;

  state_t          state;
  logic            armed;
  logic [7:0]      cmd_b0, cmd_b1, cmd_b2, cmd_b3;
  logic [BT_W-1:0] byte_timer;
  logic [RT_W-1:0] resp_timer;
  logic [7:0]      resp_data;
  logic            resp_err;
  logic            is_write;
  logic            tx_hold;

  logic accept;
  logic byte_expired;
  logic resp_expired;

  // A byte is taken only on a fresh ready (armed) and only while collecting.
  assign accept       = uart_ready && armed && (state inside {IDLE, RX1, RX2, RX3});
  assign byte_expired = (byte_timer == BT_W'(BYTE_TIMEOUT - 1));
  assign resp_expired = (resp_timer == RT_W'(RESP_TIMEOUT - 1));

  // Frame collection, bus transaction and response FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      armed          <= 1'b0;
      cmd_b0         <= '0;
      cmd_b1         <= '0;
      cmd_b2         <= '0;
      cmd_b3         <= '0;
      byte_timer     <= '0;
      resp_timer     <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      is_write       <= 1'b0;
      tx_hold        <= 1'b0;
      uart_ready_clr <= 1'b0;
      uart_data_in   <= '0;
      uart_wr_en     <= 1'b0;
      bus.bus_req    <= 1'b0;
      bus.bus_mode   <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_wdata  <= '0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
      cmd_count      <= '0;
    end else begin
      uart_ready_clr <= 1'b0;
      uart_wr_en     <= 1'b0;
      frame_err      <= 1'b0;

      // Re-arm only after ready has been seen low, so a held level counts once.
      if (accept) begin
        armed          <= 1'b0;
        uart_ready_clr <= 1'b1;
      end else if (!uart_ready) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cmd_b0     <= uart_data_out;
            byte_timer <= '0;
            state      <= RX1;
            busy       <= 1'b1;
          end
        end

        // An accept in the expiry cycle wins over the timeout.
        RX1, RX2, RX3: begin
          if (accept) begin
            byte_timer <= '0;
            case (state)
              RX1:     begin cmd_b1 <= uart_data_out; state <= RX2;   end
              RX2:     begin cmd_b2 <= uart_data_out; state <= RX3;   end
              default: begin cmd_b3 <= uart_data_out; state <= CHECK; end
            endcase
          end else if (byte_expired) begin
            byte_timer <= '0;
            frame_err  <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            byte_timer <= byte_timer + 1'b1;
          end
        end

        CHECK: begin
          if ((cmd_b2[7:4] != 4'd0) || (cmd_b3[7:1] != 7'd0)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            bus.bus_req   <= 1'b1;
            bus.bus_mode  <= cmd_b3[0];
            bus.bus_addr  <= {cmd_b2[3:0], cmd_b1};
            bus.bus_wdata <= cmd_b0;
            is_write      <= cmd_b3[0];
            resp_timer    <= '0;
            state         <= WAIT_ACK;
          end
        end

        // Ack takes priority over a coincident timeout.
        WAIT_ACK: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            resp_data   <= is_write ? cmd_b0 : bus.bus_rdata;
            resp_err    <= 1'b0;
            state       <= TX0;
          end else if (resp_expired) begin
            bus.bus_req <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b1;
            frame_err   <= 1'b1;
            state       <= TX0;
          end else begin
            resp_timer <= resp_timer + 1'b1;
          end
        end

        TX0: begin
          if (!uart_tx_busy) begin
            uart_data_in <= resp_data;
            uart_wr_en   <= 1'b1;
            tx_hold      <= 1'b1;
            state        <= TXW0;
          end
        end

        // First cycle after a load is skipped: TX core raises busy one cycle late.
        TXW0: begin
          if (tx_hold) begin
            tx_hold <= 1'b0;
          end else if (!uart_tx_busy) begin
            state <= TX1;
          end
        end

        TX1: begin
          if (!uart_tx_busy) begin
            uart_data_in <= {6'b0, resp_err, is_write};
            uart_wr_en   <= 1'b1;
            tx_hold      <= 1'b1;
            state        <= TXW1;
          end
        end

        TXW1: begin
          if (tx_hold) begin
            tx_hold <= 1'b0;
          end else if (!uart_tx_busy) begin
            cmd_count <= cmd_count + 16'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
`timescale 1ns/1ps
// Randomized bench for uart_cmd_responder with a frame-level reference model,
// a 100-cycle TX busy model and a responsive bus slave.
module tb_uart_cmd_responder;

  localparam int unsigned BT          = 200;
  localparam int unsigned RT          = 16;
  localparam int unsigned TX_BUSY_CYC = 100;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_data_out;
  logic        uart_ready;
  logic        uart_ready_clr;
  logic [7:0]  uart_data_in;
  logic        uart_wr_en;
  logic        uart_tx_busy;
  logic        busy;
  logic        frame_err;
  logic [15:0] cmd_count;

  uart_cmd_responder_if bus_if ();

  uart_cmd_responder #(
    .BYTE_TIMEOUT(BT),
    .RESP_TIMEOUT(RT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_data_out  (uart_data_out),
    .uart_ready     (uart_ready),
    .uart_ready_clr (uart_ready_clr),
    .uart_data_in   (uart_data_in),
    .uart_wr_en     (uart_wr_en),
    .uart_tx_busy   (uart_tx_busy),
    .bus            (bus_if.master),
    .busy           (busy),
    .frame_err      (frame_err),
    .cmd_count      (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus knobs (written by the main sequence only).
  bit         ack_en;
  int         ack_delay;
  logic [7:0] rdata_next;

  // Observations (written by the monitor only).
  logic [7:0]  tx_got[$];
  int          wr_cycs[$];
  logic [20:0] txn_got[$];
  int          ferr_cnt = 0;
  int          clr_cnt = 0;
  int          last_clr_cyc = 0;
  int          last_ferr_cyc = 0;
  int          tx_left = 0;
  int          tx_viol = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  int          bus_unstable = 0;
  int          ack_cnt = 0;
  bit          req_d = 1'b0;
  logic [20:0] txn_cur = '0;

  // TX busy model, bus slave and event recorder.
  always @(negedge clk) begin
    if (rst) begin
      uart_tx_busy     = 1'b0;
      tx_left          = 0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 8'h00;
      req_d            = 1'b0;
    end else begin
      if (uart_ready_clr) begin
        clr_cnt++;
        last_clr_cyc = cyc;
      end
      if (frame_err) begin
        ferr_cnt++;
        last_ferr_cyc = cyc;
      end
      if (uart_wr_en) begin
        if (uart_tx_busy) tx_viol++;
        tx_got.push_back(uart_data_in);
        wr_cycs.push_back(cyc);
        tx_left      = TX_BUSY_CYC;
        uart_tx_busy = 1'b1;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) uart_tx_busy = 1'b0;
      end
      if (bus_if.bus_req) begin
        if (!req_d) begin
          txn_cur = {bus_if.bus_mode, bus_if.bus_addr, bus_if.bus_wdata};
          txn_got.push_back(txn_cur);
          req_len = 0;
          ack_cnt = ack_delay;
        end else if ({bus_if.bus_mode, bus_if.bus_addr, bus_if.bus_wdata} != txn_cur) begin
          bus_unstable++;
        end
        req_len++;
      end else if (req_d) begin
        last_req_len = req_len;
      end
      req_d = bus_if.bus_req;
      if (bus_if.bus_ack) begin
        bus_if.bus_ack = 1'b0;
      end else if (bus_if.bus_req && ack_en) begin
        if (ack_cnt == 0) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = rdata_next;
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: what the far end must do with one 4-byte command.
  function automatic void ref_model(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3,
                                    input bit acked, input logic [7:0] rd,
                                    output bit ok, output bit is_wr, output int addr,
                                    output logic [7:0] r0, output logic [7:0] r1);
    int err;
    ok    = (int'(b2) < 16) && (int'(b3) < 2);
    is_wr = (b3 == 8'd1);
    addr  = int'(b2) * 256 + int'(b1);
    err   = acked ? 0 : 1;
    r0    = !acked ? 8'h00 : (is_wr ? b0 : rd);
    r1    = 8'(2 * err + (is_wr ? 1 : 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    uart_data_out = b;
    uart_ready    = 1'b1;
    repeat (2) @(negedge clk);
    uart_ready    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("idle", 32'(busy), 0);
  endtask

  // edge_b1: B1 is presented so that it is sampled exactly on the byte-timer expiry edge.
  task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input bit ack_on, input logic [7:0] rd, input int delay,
                           input int gap, input bit chk_lat, input bit edge_b1);
    bit ok, is_wr;
    int addr, t0, q0, f0, c0, v0, u0, t;
    logic [7:0] r0, r1;
    ref_model(d0, d1, d2, d3, ack_on, rd, ok, is_wr, addr, r0, r1);
    ack_en     = ack_on;
    rdata_next = rd;
    ack_delay  = delay;
    t0 = tx_got.size();
    q0 = txn_got.size();
    f0 = ferr_cnt;
    c0 = clr_cnt;
    v0 = tx_viol;
    u0 = bus_unstable;
    send_byte(d0, gap);
    if (edge_b1) begin
      t = last_clr_cyc + BT - 1;
      while (cyc < t) @(negedge clk);
      send_byte(d1, 0);
    end else begin
      send_byte(d1, gap);
    end
    send_byte(d2, gap);
    send_byte(d3, gap);
    wait_idle();
    check_eq("clr_pulses", 32'(clr_cnt - c0), 4);
    if (ok) begin
      exp_count++;
      check_eq("txn_n", 32'(txn_got.size() - q0), 1);
      if (txn_got.size() > q0)
        check_eq("txn", 32'(txn_got[q0]), 32'({is_wr, 12'(addr), d0}));
      check_eq("bus_stable", 32'(bus_unstable - u0), 0);
      check_eq("tx_n", 32'(tx_got.size() - t0), 2);
      if (tx_got.size() >= t0 + 2) begin
        check_eq("tx_r0", 32'(tx_got[t0]), 32'(r0));
        check_eq("tx_r1", 32'(tx_got[t0 + 1]), 32'(r1));
      end
      check_eq("tx_wr_while_busy", 32'(tx_viol - v0), 0);
      check_eq("ferr_n", 32'(ferr_cnt - f0), ack_on ? 0 : 1);
      if (!ack_on) check_eq("req_len", 32'(last_req_len), RT);
      // From the cycle B3 is sampled to the cycle R0's load pulse is high.
      if (chk_lat && wr_cycs.size() > t0)
        check_eq("lat_r0", 32'(wr_cycs[t0] - last_clr_cyc + 1), 4);
    end else begin
      check_eq("bad_txn_n", 32'(txn_got.size() - q0), 0);
      check_eq("bad_tx_n", 32'(tx_got.size() - t0), 0);
      check_eq("bad_ferr_n", 32'(ferr_cnt - f0), 1);
    end
    check_eq("cmd_count", 32'(cmd_count), 32'(exp_count));
  endtask

  initial begin
    logic [7:0] d0, d1, d2, d3;
    int f0, t0, q0, l0, n;
    rst           = 1'b1;
    uart_ready    = 1'b0;
    uart_data_out = 8'h00;
    ack_en        = 1'b1;
    ack_delay     = 0;
    rdata_next    = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_req", 32'(bus_if.bus_req), 0);
    check_eq("rst_wr_en", 32'(uart_wr_en), 0);
    check_eq("rst_clr", 32'(uart_ready_clr), 0);
    check_eq("rst_ferr", 32'(frame_err), 0);
    check_eq("rst_count", 32'(cmd_count), 0);
    check_eq("rst_data_in", 32'(uart_data_in), 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8'hAA, 8'h23, 8'h01, 8'h01, 1'b1, 8'h5A, 0, 100, 1'b1, 1'b0);
    run_frame(8'h00, 8'h56, 8'h04, 8'h00, 1'b1, 8'hBB, 0, 100, 1'b0, 1'b0);
    run_frame(8'h11, 8'h22, 8'h03, 8'h03, 1'b1, 8'h00, 0, 20, 1'b0, 1'b0);
    run_frame(8'h5C, 8'hE7, 8'h09, 8'h01, 1'b1, 8'h00, 2, 10, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      d2 = 8'($urandom_range(0, 15));
      d3 = 8'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) d2 = d2 | 8'(16 << $urandom_range(0, 3));
        else                           d3 = d3 | 8'(2 << $urandom_range(0, 6));
      end
      run_frame(d0, d1, d2, d3, $urandom_range(0, 4) != 0, 8'($urandom),
                int'($urandom_range(0, 6)), int'($urandom_range(1, 40)), 1'b0, 1'b0);
    end

    // Byte timeout after two bytes, then a clean frame.
    f0 = ferr_cnt;
    t0 = tx_got.size();
    q0 = txn_got.size();
    send_byte(8'($urandom), 10);
    send_byte(8'($urandom), 10);
    l0 = last_clr_cyc;
    repeat (BT + 20) @(negedge clk);
    check_eq("bto_ferr_n", 32'(ferr_cnt - f0), 1);
    check_eq("bto_when", 32'(last_ferr_cyc - l0), BT);
    check_eq("bto_idle", 32'(busy), 0);
    check_eq("bto_txn_n", 32'(txn_got.size() - q0), 0);
    check_eq("bto_tx_n", 32'(tx_got.size() - t0), 0);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), 8'h01,
              1'b1, 8'h00, 1, 15, 1'b0, 1'b0);

    // Byte landing on the expiry edge is kept.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), 8'h00,
              1'b1, 8'($urandom), 0, 5, 1'b0, 1'b1);

    // Response timeout on a read.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), 8'h00,
              1'b0, 8'h00, 0, 8, 1'b0, 1'b0);

    // Reset while waiting for the bus.
    ack_en = 1'b0;
    f0 = ferr_cnt;
    t0 = tx_got.size();
    send_byte(8'h33, 5);
    send_byte(8'h44, 5);
    send_byte(8'h05, 5);
    send_byte(8'h00, 5);
    n = 0;
    while (!bus_if.bus_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rm_req_seen", 32'(bus_if.bus_req), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rm_busy", 32'(busy), 0);
    check_eq("rm_req", 32'(bus_if.bus_req), 0);
    check_eq("rm_addr", 32'(bus_if.bus_addr), 0);
    check_eq("rm_count", 32'(cmd_count), 0);
    check_eq("rm_wr_en", 32'(uart_wr_en), 0);
    check_eq("rm_ferr", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("rm_tx_n", 32'(tx_got.size() - t0), 0);
    check_eq("rm_ferr_n", 32'(ferr_cnt - f0), 0);
    check_eq("rm_idle", 32'(busy), 0);
    check_eq("rm_count_after", 32'(cmd_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
